// File: rtl/golden_nonce_tx_pkg.sv
// Shared miner package for the golden-nonce UART path.
// Holds the transmitter FSM state encoding and the nonce frame geometry. The baud
// divider is not kept here because it is set per instance.
package golden_nonce_tx_pkg;

  localparam int unsigned BYTES_PER_NONCE = 4;
  localparam int unsigned BITS_PER_BYTE   = 8;
  localparam int unsigned NONCE_W         = BYTES_PER_NONCE * BITS_PER_BYTE;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

endpackage

// File: rtl/golden_nonce_tx_fifo.sv
// nonce_fifo: single-clock synchronous FIFO for queued golden nonces.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   push_i, wdata_i       write strobe and data
//   pop_i                 read strobe; rdata_o is the current head (valid when !empty_o)
//   flush_i               discard all entries; overrides push and pop
//   count_o, full_o, empty_o  occupancy
// A push while full is accepted only if a pop happens in the same cycle.
module nonce_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i & ~empty_o & ~flush_i & ~rst_i;
  assign push_ok = push_i & (~full_o | pop_ok) & ~flush_i & ~rst_i;

  always_comb begin
    count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
    if (flush_i) count_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset; when full and popping, the head is read before it is overwritten.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/golden_nonce_tx.sv
// golden_nonce_tx: queues golden nonces from the hash core and sends each one over a
// UART line (8N1, idle high) as four bytes, least-significant byte first.
// Ports:
//   hash_clk, reset      clock, synchronous active-high reset
//   gn_valid, gn_data    one-cycle nonce strobe and 32-bit nonce
//   flush                new work: drop queued nonces (a frame already on the wire finishes)
//   txd                  serial output
//   busy                 frame in progress or queue non-empty
//   overflow             sticky, set when a nonce is dropped because the queue is full
//   fifo_count           queued nonces
module golden_nonce_tx
  import golden_nonce_tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         hash_clk,
  input  logic                         reset,
  input  logic                         gn_valid,
  input  logic [31:0]                  gn_data,
  input  logic                         flush,
  output logic                         txd,
  output logic                         busy,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned BaudW = $clog2(BAUD_DIV);
  localparam int unsigned BitW  = $clog2(BITS_PER_BYTE);
  localparam int unsigned ByteW = $clog2(BYTES_PER_NONCE);
  localparam logic [BaudW-1:0] BaudReload = BaudW'(BAUD_DIV - 1);

  tx_state_e          state_q;
  logic [BaudW-1:0]   baud_q;
  logic [BitW-1:0]    bit_idx_q;
  logic [ByteW-1:0]   byte_idx_q;
  logic [NONCE_W-1:0] shift_q;
  logic               txd_q, busy_q, overflow_q;

  logic [NONCE_W-1:0] fifo_rdata;
  logic               fifo_full, fifo_empty;
  logic               pop, drop;

  assign pop  = (state_q == StIdle) & ~fifo_empty & ~flush;
  assign drop = gn_valid & ~flush & fifo_full & ~pop;

  nonce_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (NONCE_W)
  ) u_fifo (
    .clk_i   (hash_clk),
    .rst_i   (reset),
    .push_i  (gn_valid),
    .wdata_i (gn_data),
    .pop_i   (pop),
    .flush_i (flush),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // txd is registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q    <= fifo_rdata;
            byte_idx_q <= '0;
            baud_q     <= BaudReload;
            state_q    <= StStart;
          end
        end
        StStart: begin
          txd_q <= 1'b0;
          if (baud_q == '0) begin
            baud_q    <= BaudReload;
            bit_idx_q <= '0;
            state_q   <= StData;
          end else begin
            baud_q <= baud_q - BaudW'(1);
          end
        end
        StData: begin
          txd_q <= shift_q[0];
          if (baud_q == '0) begin
            baud_q  <= BaudReload;
            shift_q <= shift_q >> 1;
            if (bit_idx_q == BitW'(BITS_PER_BYTE - 1)) begin
              bit_idx_q <= '0;
              state_q   <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + BitW'(1);
            end
          end else begin
            baud_q <= baud_q - BaudW'(1);
          end
        end
        StStop: begin
          txd_q <= 1'b1;
          if (baud_q == '0) begin
            baud_q <= BaudReload;
            if (byte_idx_q != ByteW'(BYTES_PER_NONCE - 1)) begin
              byte_idx_q <= byte_idx_q + ByteW'(1);
              state_q    <= StStart;
            end else begin
              byte_idx_q <= '0;
              state_q    <= StIdle;
            end
          end else begin
            baud_q <= baud_q - BaudW'(1);
          end
        end
      endcase
      busy_q     <= (state_q != StIdle) | (fifo_count != '0);
      overflow_q <= overflow_q | drop;
    end
  end

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule
